// File: rtl/mips_pkg.sv
// Shared types for the multiply/divide unit: operation encodings and controller states.
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative datapath: shift-add multiply or restoring shift-subtract divide.
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] res_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    // Multiply keeps the multiplier in the low half; divide keeps the partial remainder in the high half.
    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        rem  = acc[2*WIDTH-1:WIDTH-1];
        diff = rem - {1'b0, opnd};
        if (is_div) begin
            if (diff[WIDTH]) begin
                res_c = {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                res_c = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            res_c = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mdu
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = 2 * WIDTH;

    mdu_state_t       state;
    mdu_state_t       state_nxt;
    logic [CW-1:0]    counter;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    step_c;
    logic [WIDTH-1:0] opnd;
    logic             neg_q;
    logic             neg_r;
    logic             is_div;

    logic             accept_c;
    logic             last_c;
    logic             signed_op_c;
    logic             sign_a_c;
    logic             sign_b_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] quot_c;
    logic [WIDTH-1:0] rem_c;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc    (acc),
        .opnd   (opnd),
        .res_c  (step_c)
    );

    // Operand magnitudes and final sign correction.
    always_comb begin
        signed_op_c = ~op[0];
        sign_a_c    = signed_op_c & a[WIDTH-1];
        sign_b_c    = signed_op_c & b[WIDTH-1];
        mag_a_c     = sign_a_c ? (WIDTH'(0) - a) : a;
        mag_b_c     = sign_b_c ? (WIDTH'(0) - b) : b;
        prod_c      = neg_q ? (AW'(0) - acc) : acc;
        quot_c      = neg_q ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_c       = neg_r ? (WIDTH'(0) - acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = (counter == CW'(WIDTH - 1));
        unique case (state)
            IDLE: begin
                if (start && !flush && !op[2]) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last_c) begin
                    state_nxt = FIXUP;
                end
            end
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_div  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= 1'b0;
            if (accept_c) begin
                counter <= '0;
                is_div  <= op[1];
                neg_r   <= sign_a_c;
                // A zero divisor yields an all-ones quotient that must not be sign-corrected.
                neg_q   <= (sign_a_c ^ sign_b_c) & (!op[1] || (b != '0));
                acc     <= op[1] ? {WIDTH'(0), mag_a_c} : {WIDTH'(0), mag_b_c};
                opnd    <= op[1] ? mag_b_c : mag_a_c;
            end else if (state == RUN && !flush) begin
                acc     <= step_c;
                counter <= counter + CW'(1);
            end
            if (state == IDLE && start && !flush) begin
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end
            if (state == FIXUP && !flush) begin
                done <= 1'b1;
                if (is_div) begin
                    hi <= rem_c;
                    lo <= quot_c;
                end else begin
                    hi <= prod_c[AW-1:WIDTH];
                    lo <= prod_c[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized ops against an arithmetic model.
module tb_mdu;
    import mips_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi,lo} from plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            3'b000: return 64'(sx * sy);
            3'b001: return ux * uy;
            3'b010: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            default: return {hi_m, lo_m};
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Issues a mul/div and measures edges to done, busy cycles and done one cycle later.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt, output logic d_after);
        issue(o, x, y);
        lat     = 0;
        bcnt    = busy ? 1 : 0;
        d_after = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat != 0) begin
            @(posedge clk);
            #1;
            d_after = done;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0; op = 3'b0; a = '0; b = '0; flush = 1'b0;
        hi_m = '0; lo_m = '0;
        #23;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [2:0]  dop [6];
        logic [31:0] da  [6];
        logic [31:0] db  [6];
        logic [63:0] exp_v;
        int lat;
        int bcnt;
        logic d_after;
        dop[0] = 3'b000; da[0] = 32'hFFFFFFFD; db[0] = 32'd5;
        dop[1] = 3'b001; da[1] = 32'hFFFFFFFF; db[1] = 32'hFFFFFFFF;
        dop[2] = 3'b010; da[2] = 32'hFFFFFFF9; db[2] = 32'd2;
        dop[3] = 3'b011; da[3] = 32'd7;        db[3] = 32'd2;
        dop[4] = 3'b010; da[4] = 32'h80000000; db[4] = 32'hFFFFFFFF;
        dop[5] = 3'b011; da[5] = 32'd5;        db[5] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            exp_v = ref_md(dop[i], da[i], db[i]);
            run_op(dop[i], da[i], db[i], lat, bcnt, d_after);
            hi_m = exp_v[63:32];
            lo_m = exp_v[31:0];
            checks += 5;
            if (hi !== hi_m) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, hi_m); end
            if (lo !== lo_m) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, lo_m); end
            if (lat != 33) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=33", i, lat); end
            if (bcnt != 33) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bcnt); end
            if (d_after !== 1'b0) begin failures++; $display("FAIL dir%0d_done_width got=%b exp=0", i, d_after); end
            if (i == 0) begin
                checks++;
                if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
                    failures++; $display("FAIL mult_neg3x5 got=%h exp=ffffffff_fffffff1", {hi, lo});
                end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] corner [5];
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp_v;
        int lat;
        int bcnt;
        logic d_after;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(8, 28);
            exp_v = ref_md(o, x, y);
            run_op(o, x, y, lat, bcnt, d_after);
            hi_m = exp_v[63:32];
            lo_m = exp_v[31:0];
            checks += 3;
            if (hi !== hi_m) begin failures++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, hi, hi_m); end
            if (lo !== lo_m) begin failures++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, lo, lo_m); end
            if (lat != 33) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=33", i, lat); end
        end
    endtask

    task automatic test_mt_and_illegal;
        issue(3'b100, 32'hCAFE0001, 32'h0);
        hi_m = 32'hCAFE0001;
        issue(3'b101, 32'hBEEF0002, 32'h0);
        lo_m = 32'hBEEF0002;
        checks += 3;
        if (hi !== hi_m) begin failures++; $display("FAIL mthi got=%h exp=%h", hi, hi_m); end
        if (lo !== lo_m) begin failures++; $display("FAIL mtlo got=%h exp=%h", lo, lo_m); end
        if (busy !== 1'b0) begin failures++; $display("FAIL mt_busy got=%b exp=0", busy); end
        issue(3'b110, 32'h11111111, 32'h2);
        issue(3'b111, 32'h22222222, 32'h3);
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL illegal_busy got=%b exp=0", busy); end
        if (hi !== hi_m) begin failures++; $display("FAIL illegal_hi got=%h exp=%h", hi, hi_m); end
        if (lo !== lo_m) begin failures++; $display("FAIL illegal_lo got=%h exp=%h", lo, lo_m); end
    endtask

    task automatic test_flush;
        logic saw_done;
        issue(3'b100, 32'h1234, 32'h0);
        hi_m = 32'h1234;
        issue(3'b010, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checks += 3;
        if (saw_done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", saw_done); end
        if (hi !== 32'h1234) begin failures++; $display("FAIL flush_hi got=%h exp=00001234", hi); end
        if (lo !== lo_m) begin failures++; $display("FAIL flush_lo got=%h exp=%h", lo, lo_m); end
        // flush coinciding with start in IDLE suppresses even MTLO
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'h55; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checks += 2;
        if (lo !== lo_m) begin failures++; $display("FAIL flush_idle_lo got=%h exp=%h", lo, lo_m); end
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_v;
        int lat;
        exp_v = ref_md(3'b011, 32'd100, 32'd7);
        issue(3'b011, 32'd100, 32'd7);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 3 || i == 20) begin
                @(negedge clk);
                start = 1'b1;
                op = (i == 3) ? 3'b100 : 3'b000;
                a = 32'hDEADBEEF;
                b = 32'd3;
                @(posedge clk);
                #1;
                start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        hi_m = exp_v[63:32];
        lo_m = exp_v[31:0];
        checks += 3;
        if (lat != 33) begin failures++; $display("FAIL busy_start_latency got=%0d exp=33", lat); end
        if (hi !== hi_m) begin failures++; $display("FAIL busy_start_hi got=%h exp=%h", hi, hi_m); end
        if (lo !== lo_m) begin failures++; $display("FAIL busy_start_lo got=%h exp=%h", lo, lo_m); end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_queued got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        issue(3'b000, 32'h12345678, 32'h9ABCDEF0);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
        if (hi !== 32'h0) begin failures++; $display("FAIL async_reset_hi got=%h exp=0", hi); end
        if (lo !== 32'h0) begin failures++; $display("FAIL async_reset_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset_n = 1'b1;
        issue(3'b101, 32'd9, 32'd0);
        lo_m = 32'd9;
        checks += 2;
        if (lo !== 32'd9) begin failures++; $display("FAIL post_reset_mtlo got=%h exp=9", lo); end
        if (hi !== 32'h0) begin failures++; $display("FAIL post_reset_hi got=%h exp=0", hi); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_mt_and_illegal();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
